// File: rtl/alu32_exec_stage.sv
// Registered execute stage around the combinational alu32: operand slot (S1),
// result buffer (S2) with valid/ready on both sides, sticky flags and an op counter.
module alu32_exec_stage #(
   parameter int TAG_W = 4,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_a,
   input  logic [31:0]      in_b,
   input  logic [2:0]       in_op,
   input  logic [TAG_W-1:0] in_tag,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [2:0]       alu_op,
   input  logic [31:0]      alu_result,
   input  logic             alu_c,
   input  logic             alu_n,
   input  logic             alu_z,
   input  logic             alu_v,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic [3:0]       out_flags,
   output logic [TAG_W-1:0] out_tag,
   input  logic             flag_clr,
   output logic [3:0]       sticky_flags,
   output logic [CNT_W-1:0] op_count
);

   logic             s1_valid_reg;
   logic [31:0]      s1_a_reg;
   logic [31:0]      s1_b_reg;
   logic [2:0]       s1_op_reg;
   logic [TAG_W-1:0] s1_tag_reg;

   logic             out_valid_reg;
   logic [31:0]      out_result_reg;
   logic [3:0]       out_flags_reg;
   logic [TAG_W-1:0] out_tag_reg;
   logic [3:0]       sticky_reg;
   logic [3:0]       sticky_next;
   logic [CNT_W-1:0] count_reg;

   logic       s2_free;
   logic       s1_move;
   logic       accept;
   logic       drain;
   logic [3:0] alu_flags;

   assign s2_free   = !out_valid_reg || out_ready;
   assign s1_move   = s1_valid_reg && s2_free;
   assign in_ready  = !reset && (!s1_valid_reg || s2_free);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid_reg && out_ready;
   assign alu_flags = {alu_n, alu_z, alu_c, alu_v};

   // The ALU sees zeros whenever the operand slot is empty.
   assign alu_a  = s1_valid_reg ? s1_a_reg  : 32'd0;
   assign alu_b  = s1_valid_reg ? s1_b_reg  : 32'd0;
   assign alu_op = s1_valid_reg ? s1_op_reg : 3'd0;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1_valid_reg <= 1'b0;
         s1_a_reg     <= '0;
         s1_b_reg     <= '0;
         s1_op_reg    <= '0;
         s1_tag_reg   <= '0;
      end else if (accept) begin
         s1_valid_reg <= 1'b1;
         s1_a_reg     <= in_a;
         s1_b_reg     <= in_b;
         s1_op_reg    <= in_op;
         s1_tag_reg   <= in_tag;
      end else if (s1_move) begin
         s1_valid_reg <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_reg  <= 1'b0;
         out_result_reg <= '0;
         out_flags_reg  <= '0;
         out_tag_reg    <= '0;
      end else if (s1_move) begin
         out_valid_reg  <= 1'b1;
         out_result_reg <= alu_result;
         out_flags_reg  <= alu_flags;
         out_tag_reg    <= s1_tag_reg;
      end else if (drain) begin
         out_valid_reg  <= 1'b0;
      end
   end

   // A clear in the same cycle as a capture keeps only the newly captured flags.
   for (genvar gi = 0; gi < 4; gi++) begin : g_sticky
      always_comb begin
         sticky_next[gi] = sticky_reg[gi];
         if (flag_clr)
            sticky_next[gi] = 1'b0;
         if (s1_move)
            sticky_next[gi] = sticky_next[gi] | alu_flags[gi];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sticky_reg <= '0;
         count_reg  <= '0;
      end else begin
         sticky_reg <= sticky_next;
         if (drain)
            count_reg <= count_reg + 1'b1;
      end
   end

   assign out_valid    = out_valid_reg;
   assign out_result   = out_result_reg;
   assign out_flags    = out_flags_reg;
   assign out_tag      = out_tag_reg;
   assign sticky_flags = sticky_reg;
   assign op_count     = count_reg;

endmodule

// File: tb/tb_alu32_exec_stage.sv
// Directed bench for alu32_exec_stage with an adder standing in for alu32;
// a narrow counter width lets the op_count wrap be reached quickly.
module tb_alu32_exec_stage;

   localparam int TAG_W = 4;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_a;
   logic [31:0]      in_b;
   logic [2:0]       in_op;
   logic [TAG_W-1:0] in_tag;
   logic [31:0]      alu_a;
   logic [31:0]      alu_b;
   logic [2:0]       alu_op;
   logic [31:0]      alu_result;
   logic             alu_c, alu_n, alu_z, alu_v;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_result;
   logic [3:0]       out_flags;
   logic [TAG_W-1:0] out_tag;
   logic             flag_clr;
   logic [3:0]       sticky_flags;
   logic [CNT_W-1:0] op_count;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   alu32_exec_stage #(.TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
      .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_result(alu_result),
      .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
      .flag_clr(flag_clr), .sticky_flags(sticky_flags), .op_count(op_count)
   );

   // Adder stub for alu32.
   logic [32:0] sum33;
   assign sum33      = {1'b0, alu_a} + {1'b0, alu_b};
   assign alu_result = sum33[31:0];
   assign alu_c      = sum33[32];
   assign alu_n      = sum33[31];
   assign alu_z      = (sum33[31:0] == 32'd0);
   assign alu_v      = (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_tag   = t;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
      out_ready = 1'b0; flag_clr = 1'b0;

      // Reset state
      cyc(); cyc(); cyc();
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_op_count", op_count, 0);
      chk("rst_sticky", sticky_flags, 0);
      chk("rst_alu_a", alu_a, 0);
      chk("rst_out_result", out_result, 0);
      reset = 1'b0;
      #1;
      chk("idle_in_ready", in_ready, 1);

      // Single op, opcode passed through untouched
      out_ready = 1'b1;
      drive(32'h5, 32'h3, 4'h1);
      in_op = 3'b111;
      cyc();
      in_valid = 1'b0;
      chk("single_alu_a", alu_a, 32'h5);
      chk("single_alu_b", alu_b, 32'h3);
      chk("single_alu_op", alu_op, 3'b111);
      chk("single_not_yet_valid", out_valid, 0);
      cyc();
      chk("single_out_valid", out_valid, 1);
      chk("single_result", out_result, 32'h8);
      chk("single_flags", out_flags, 4'b0000);
      chk("single_tag", out_tag, 4'h1);
      chk("single_alu_empty", alu_a, 0);
      cyc();
      chk("single_drained", out_valid, 0);
      chk("single_count", op_count, 1);
      in_op = 3'b000;

      // Flag generation and sticky accumulation
      drive(32'hFFFF_FFFF, 32'h1, 4'h2);
      cyc(); in_valid = 1'b0; cyc();
      chk("carry_result", out_result, 32'h0);
      chk("carry_flags", out_flags, 4'b0110);
      chk("carry_sticky", sticky_flags, 4'b0110);
      cyc();
      drive(32'h7FFF_FFFF, 32'h1, 4'h3);
      cyc(); in_valid = 1'b0; cyc();
      chk("ovf_result", out_result, 32'h8000_0000);
      chk("ovf_flags", out_flags, 4'b1001);
      chk("ovf_sticky", sticky_flags, 4'b1111);
      cyc();
      chk("flags_count", op_count, 3);

      // Backpressure: two accepts fill both slots, then in_ready drops
      out_ready = 1'b0;
      drive(32'h1000_0000, 32'h0, 4'h4);
      #1; chk("bp_ready0", in_ready, 1);
      cyc();
      drive(32'h1000_0001, 32'h1, 4'h5);
      #1; chk("bp_ready1", in_ready, 1);
      cyc();
      drive(32'h1000_0002, 32'h2, 4'h6);
      #1; chk("bp_ready_drop", in_ready, 0);
      chk("bp_hold_result0", out_result, 32'h1000_0000);
      cyc(); cyc();
      chk("bp_hold_result", out_result, 32'h1000_0000);
      chk("bp_hold_tag", out_tag, 4'h4);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_s1_hold", alu_a, 32'h1000_0001);
      chk("bp_still_blocked", in_ready, 0);
      out_ready = 1'b1;
      #1; chk("bp_release_ready", in_ready, 1);
      cyc();
      chk("bp_res1", out_result, 32'h1000_0002);
      chk("bp_tag1", out_tag, 4'h5);
      drive(32'h1000_0003, 32'h3, 4'h7);
      cyc();
      chk("bp_res2", out_result, 32'h1000_0004);
      chk("bp_tag2", out_tag, 4'h6);
      in_valid = 1'b0;
      cyc();
      chk("bp_res3", out_result, 32'h1000_0006);
      chk("bp_tag3", out_tag, 4'h7);
      cyc();
      chk("bp_empty", out_valid, 0);
      chk("bp_count", op_count, 7);

      // Full throughput: one result per cycle after the first
      for (int i = 0; i < 20; i++) begin
         drive(i, 32'h64, i[TAG_W-1:0]);
         cyc();
         chk("tp_ready", in_ready, 1);
         if (i == 0) begin
            chk("tp_first_latency", out_valid, 0);
         end else begin
            chk("tp_valid", out_valid, 1);
            chk("tp_result", out_result, 32'h64 + i - 1);
            chk("tp_tag", out_tag, (i - 1) % 16);
         end
      end
      in_valid = 1'b0;
      cyc();
      chk("tp_last_result", out_result, 32'h64 + 19);
      chk("tp_last_tag", out_tag, 4'h3);
      cyc();
      chk("tp_empty", out_valid, 0);
      chk("tp_count", op_count, 27);
      chk("tp_sticky", sticky_flags, 4'b1111);

      // Clear coinciding with a capture keeps only the new flags
      drive(32'h0, 32'h0, 4'h9);
      cyc();
      in_valid = 1'b0;
      flag_clr = 1'b1;
      cyc();
      flag_clr = 1'b0;
      chk("clr_capture_flags", out_flags, 4'b0100);
      chk("clr_capture_sticky", sticky_flags, 4'b0100);
      cyc();
      flag_clr = 1'b1;
      cyc();
      flag_clr = 1'b0;
      chk("clr_alone_sticky", sticky_flags, 4'b0000);
      chk("clr_count_kept", op_count, 28);

      // Counter wrap at 2^CNT_W
      for (int j = 0; j < 4; j++) begin
         drive(j, 32'h0, 4'hC);
         cyc();
      end
      in_valid = 1'b0;
      cyc();
      chk("wrap_max", op_count, 31);
      cyc();
      chk("wrap_zero", op_count, 0);

      // Reset with both slots occupied
      out_ready = 1'b0;
      drive(32'hFFFF_FFFF, 32'h1, 4'hA);
      cyc();
      drive(32'h4, 32'h4, 4'hB);
      cyc();
      in_valid = 1'b0;
      chk("mid_full_valid", out_valid, 1);
      chk("mid_full_tag", out_tag, 4'hA);
      chk("mid_full_s1", alu_a, 32'h4);
      chk("mid_sticky", sticky_flags, 4'b0110);
      reset = 1'b1;
      #1; chk("mid_rst_ready", in_ready, 0);
      cyc();
      reset = 1'b0;
      chk("mid_rst_valid", out_valid, 0);
      chk("mid_rst_sticky", sticky_flags, 0);
      chk("mid_rst_count", op_count, 0);
      chk("mid_rst_result", out_result, 0);
      chk("mid_rst_tag", out_tag, 0);
      chk("mid_rst_alu", alu_a, 0);
      out_ready = 1'b1;
      cyc();
      chk("mid_no_ghost", out_valid, 0);
      drive(32'h2, 32'h3, 4'h5);
      cyc();
      in_valid = 1'b0;
      cyc();
      chk("post_rst_valid", out_valid, 1);
      chk("post_rst_result", out_result, 32'h5);
      chk("post_rst_tag", out_tag, 4'h5);
      cyc();
      chk("post_rst_count", op_count, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
